// File: rtl/shared_inv_transformation_iter.sv
// rtl/shared_inv_transformation_iter.sv - iterated masked division by x in GF(2^4) over two shares
module shared_inv_transformation_iter #(
  parameter int LANES = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [3:0]           in_count,
  input  logic [4*LANES-1:0]   in_share0,
  input  logic [4*LANES-1:0]   in_share1,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [4*LANES-1:0]   out_share0,
  output logic [4*LANES-1:0]   out_share1,
  output logic                 busy
);

  localparam int W = 4 * LANES;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HOLD = 2'd2
  } state_t;

  state_t         state;
  state_t         state_nxt;
  logic [3:0]     cnt;
  logic [W-1:0]   sh0;
  logic [W-1:0]   sh1;
  logic [W-1:0]   sh0_step;
  logic [W-1:0]   sh1_step;

  // Divide one nibble by x modulo x^4+x+1; inverse of shift-left with 0011 feedback.
  function automatic logic [3:0] div_x(input logic [3:0] b);
    logic [3:0] t;
    t = b ^ 4'b0011;
    if (b[0]) begin
      div_x = {1'b1, t[3:1]};
    end else begin
      div_x = {1'b0, b[3:1]};
    end
  endfunction

  // One inverse step on every lane of both shares; lanes and shares never mix.
  always_comb begin
    sh0_step = '0;
    sh1_step = '0;
    for (int i = 0; i < LANES; i++) begin
      sh0_step[4*i +: 4] = div_x(sh0[4*i +: 4]);
      sh1_step[4*i +: 4] = div_x(sh1[4*i +: 4]);
    end
  end

  // Next-state and handshake outputs.
  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    busy      = 1'b1;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        busy     = 1'b0;
        if (in_valid) begin
          state_nxt = (in_count == 4'd0) ? HOLD : RUN;
        end
      end
      RUN: begin
        if (cnt == 4'd1) begin
          state_nxt = HOLD;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Share registers and step counter: load on accept, step while running, freeze otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= 4'd0;
      sh0 <= '0;
      sh1 <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            cnt <= in_count;
            sh0 <= in_share0;
            sh1 <= in_share1;
          end
        end
        RUN: begin
          cnt <= cnt - 4'd1;
          sh0 <= sh0_step;
          sh1 <= sh1_step;
        end
        default: begin
          cnt <= cnt;
        end
      endcase
    end
  end

  assign out_share0 = sh0;
  assign out_share1 = sh1;

endmodule

// File: tb/tb_shared_inv_transformation_iter.sv
// tb/tb_shared_inv_transformation_iter.sv - directed self-checking bench for shared_inv_transformation_iter
module tb_shared_inv_transformation_iter;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  in_count;
  logic [31:0] in_share0;
  logic [31:0] in_share1;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_share0;
  logic [31:0] out_share1;
  logic        busy;

  int checks = 0;
  int failures = 0;

  shared_inv_transformation_iter #(.LANES(8)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_count   (in_count),
    .in_share0  (in_share0),
    .in_share1  (in_share1),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_share0 (out_share0),
    .out_share1 (out_share1),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    assert (observed === expected) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, observed, expected);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] mul_x(input logic [3:0] b);
    mul_x = {b[2:0], 1'b0} ^ (b[3] ? 4'b0011 : 4'b0000);
  endfunction

  function automatic logic [31:0] mul_x_word(input logic [31:0] w, input int n);
    logic [31:0] r;
    r = w;
    for (int k = 0; k < n; k++) begin
      for (int i = 0; i < 8; i++) begin
        r[4*i +: 4] = mul_x(r[4*i +: 4]);
      end
    end
    mul_x_word = r;
  endfunction

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_valid && lat < 40) begin
      step();
      lat++;
    end
  endtask

  task automatic run_req(input logic [3:0] n, input logic [31:0] s0, input logic [31:0] s1, output int lat);
    in_valid  = 1'b1;
    in_count  = n;
    in_share0 = s0;
    in_share1 = s1;
    step();
    in_valid  = 1'b0;
    in_count  = 4'hA;
    in_share0 = 32'h5A5A5A5A;
    in_share1 = 32'hA5A5A5A5;
    wait_out(lat);
  endtask

  task automatic handshake();
    out_ready = 1'b1;
    step();
    out_ready = 1'b0;
  endtask

  initial begin
    int lat;
    logic [31:0] r0, r1, h0, h1;
    logic [3:0]  rn;

    rst = 1'b1; in_valid = 1'b0; in_count = 4'd0;
    in_share0 = 32'd0; in_share1 = 32'd0; out_ready = 1'b0;
    step();
    step();
    rst = 1'b0;
    check("reset_in_ready", in_ready, 1'b1);
    check("reset_out_valid", out_valid, 1'b0);
    check("reset_busy", busy, 1'b0);
    check("reset_shares", {out_share0, out_share1}, 64'd0);

    // Single step
    run_req(4'd1, 32'h11111111, 32'h33333333, lat);
    check("single_latency", lat, 2);
    check("single_out_valid", out_valid, 1'b1);
    check("single_share0", out_share0, 32'h99999999);
    check("single_share1", out_share1, 32'h88888888);
    handshake();
    check("single_back_idle", in_ready, 1'b1);

    // Zero count
    run_req(4'd0, 32'hDEADBEEF, 32'h01234567, lat);
    check("zero_latency", lat, 1);
    check("zero_shares", {out_share0, out_share1}, 64'hDEADBEEF01234567);
    handshake();

    // Full order
    run_req(4'd15, 32'hDEADBEEF, 32'h01234567, lat);
    check("order15_latency", lat, 16);
    check("order15_shares", {out_share0, out_share1}, 64'hDEADBEEF01234567);
    handshake();

    // Two steps on 1 -> 9 -> D
    run_req(4'd2, 32'h11111111, 32'h00000000, lat);
    check("two_latency", lat, 3);
    check("two_shares", {out_share0, out_share1}, 64'hDDDDDDDD00000000);
    handshake();

    // Round trip through the forward model
    for (int it = 0; it < 4; it++) begin
      r0 = $urandom;
      r1 = $urandom;
      rn = 4'($urandom_range(1, 14));
      run_req(rn, r0, r1, lat);
      check("rt_latency", lat, 32'(rn) + 1);
      check("rt_share0", mul_x_word(out_share0, int'(rn)), r0);
      check("rt_share1", mul_x_word(out_share1, int'(rn)), r1);
      check("rt_unmasked", mul_x_word(out_share0 ^ out_share1, int'(rn)), r0 ^ r1);
      handshake();
    end

    // Backpressure with ignored in_valid pulses
    run_req(4'd1, 32'h22222222, 32'hFFFFFFFF, lat);
    check("bp_shares", {out_share0, out_share1}, 64'h11111111EEEEEEEE);
    for (int c = 0; c < 5; c++) begin
      in_valid  = c[0];
      in_count  = 4'd3;
      in_share0 = 32'hCAFEF00D;
      in_share1 = 32'h0BADBEEF;
      step();
      check("bp_hold_valid", {out_valid, in_ready, busy}, 3'b101);
      check("bp_hold_shares", {out_share0, out_share1}, 64'h11111111EEEEEEEE);
    end
    in_valid = 1'b1;
    handshake();
    in_valid = 1'b0;
    check("bp_release_state", {out_valid, in_ready, busy}, 3'b010);

    // Reset on the 4th RUN cycle
    in_valid = 1'b1; in_count = 4'd10;
    in_share0 = 32'h12345678; in_share1 = 32'h9ABCDEF0;
    step();
    in_valid = 1'b0;
    step();
    step();
    step();
    check("rst_mid_busy_before", busy, 1'b1);
    rst = 1'b1;
    out_ready = 1'b1;
    step();
    rst = 1'b0;
    out_ready = 1'b0;
    check("rst_mid_state", {busy, out_valid, in_ready}, 3'b001);
    check("rst_mid_shares", {out_share0, out_share1}, 64'd0);
    run_req(4'd1, 32'h11111111, 32'h33333333, lat);
    check("rst_after_latency", lat, 2);
    check("rst_after_shares", {out_share0, out_share1}, 64'h9999999988888888);
    handshake();

    // Back-to-back requests held on the input
    in_valid = 1'b1; in_count = 4'd2;
    in_share0 = 32'h11111111; in_share1 = 32'h00000000;
    step();
    in_count = 4'd0;
    in_share0 = 32'h12345678; in_share1 = 32'h87654321;
    wait_out(lat);
    check("b2b_first_latency", lat, 3);
    check("b2b_first_shares", {out_share0, out_share1}, 64'hDDDDDDDD00000000);
    handshake();
    check("b2b_not_accepted_on_handshake", {in_ready, busy}, 2'b10);
    step();
    in_valid = 1'b0;
    h0 = out_share0;
    h1 = out_share1;
    check("b2b_second_latency_valid", out_valid, 1'b1);
    check("b2b_second_shares", {h0, h1}, 64'h1234567887654321);
    handshake();
    check("b2b_final_idle", {out_valid, in_ready, busy}, 3'b010);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
